// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I core: states, opcodes, ALU ops, bus encodings.
package cpu_pkg;

  typedef enum logic [1:0] {StFetch, StDecode, StExecute, StMemwb} state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [31:0] InstrMret = 32'h3020_0073;
  localparam logic [31:0] IrqVector = 32'h0000_0010;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  // Control bus: [0] read, [1] write, [3:2] size
  localparam logic [3:0] CtrlIdle  = 4'b0000;
  localparam logic [3:0] CtrlFetch = 4'b1001;
  localparam logic [1:0] CtrlRead  = 2'b01;
  localparam logic [1:0] CtrlWrite = 2'b10;

  function automatic logic [31:0] imm_gen(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OpStore:        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OpBranch:       imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OpLui, OpAuipc: imm = {ir[31:12], 12'h000};
      OpJal:          imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      default:        imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    return imm;
  endfunction

  function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    unique case (op)
      AluSub:  r = a - b;
      AluSll:  r = a << b[4:0];
      AluSlt:  r = {31'd0, $signed(a) < $signed(b)};
      AluSltu: r = {31'd0, a < b};
      AluXor:  r = a ^ b;
      AluSrl:  r = a >> b[4:0];
      AluSra:  r = $unsigned($signed(a) >>> b[4:0]);
      AluOr:   r = a | b;
      AluAnd:  r = a & b;
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 hardwired 0.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs_q[raddr_b];

endmodule

// File: rtl/cpu.sv
// Four-cycle (fetch/decode/execute/memwb) RV32I core with registered bus outputs.
// Define CPU_INTERRUPT_EN to include the level interrupt, EPC/IE state and MRET.
module cpu
  import cpu_pkg::*;
(
  input  logic        clk_from_external,
  input  logic        reset_from_external,
  input  logic [31:0] inputdata_from_external_bus,
  input  logic        interrupt_from_external,
  output logic [31:0] outputdata_to_external_bus,
  output logic [31:0] address_to_external_bus_from_cpu,
  output logic [3:0]  control_output_to_external_bus,
  output logic        interrupt_grant_from_pc
);

  state_e      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d, ir_q, rs1_q, rs2_q, imm_q, res_q, npc_q;
  logic        wb_q;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_a, rdata_b, alu_b, alu_res, ld_val, wb_data;
  logic [31:0] ex_npc, ex_res, ex_data;
  logic [3:0]  ex_ctrl;
  logic        ex_wb, br_taken, take_irq;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  alu_op_e     alu_op;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];

  cpu_regfile u_regfile (
    .clk     (clk_from_external),
    .rst_n   (reset_from_external),
    .raddr_a (ir_q[19:15]),
    .rdata_a (rdata_a),
    .raddr_b (ir_q[24:20]),
    .rdata_b (rdata_b),
    .we      (state_q == StMemwb && wb_q),
    .waddr   (ir_q[11:7]),
    .wdata   (wb_data)
  );

`ifdef CPU_INTERRUPT_EN
  logic        ie_q, grant_q;
  logic [31:0] epc_q;

  assign take_irq = (state_q == StMemwb) && interrupt_from_external && ie_q;
  assign interrupt_grant_from_pc = grant_q;

  always_ff @(posedge clk_from_external or negedge reset_from_external) begin
    if (!reset_from_external) begin
      ie_q    <= 1'b1;
      epc_q   <= '0;
      grant_q <= 1'b0;
    end else begin
      grant_q <= take_irq;
      if (take_irq) begin
        ie_q  <= 1'b0;
        epc_q <= npc_q;
      end else if (state_q == StMemwb && ir_q == InstrMret) begin
        ie_q <= 1'b1;
      end
    end
  end
`else
  logic unused_irq;
  assign unused_irq = interrupt_from_external;
  assign take_irq = 1'b0;
  assign interrupt_grant_from_pc = 1'b0;
`endif

  always_comb begin
    alu_op = AluAdd;
    if (opcode == OpReg || opcode == OpImm) begin
      unique case (funct3)
        3'b000: alu_op = (opcode == OpReg && ir_q[30]) ? AluSub : AluAdd;
        3'b001: alu_op = AluSll;
        3'b010: alu_op = AluSlt;
        3'b011: alu_op = AluSltu;
        3'b100: alu_op = AluXor;
        3'b101: alu_op = ir_q[30] ? AluSra : AluSrl;
        3'b110: alu_op = AluOr;
        3'b111: alu_op = AluAnd;
      endcase
    end
  end

  assign alu_b   = (opcode == OpReg) ? rs2_q : imm_q;
  assign alu_res = alu_eval(alu_op, rs1_q, alu_b);

  always_comb begin
    case (funct3)
      3'b000:  br_taken = rs1_q == rs2_q;
      3'b001:  br_taken = rs1_q != rs2_q;
      3'b100:  br_taken = $signed(rs1_q) < $signed(rs2_q);
      3'b101:  br_taken = $signed(rs1_q) >= $signed(rs2_q);
      3'b110:  br_taken = rs1_q < rs2_q;
      3'b111:  br_taken = rs1_q >= rs2_q;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    ex_npc  = pc_q + 32'd4;
    ex_res  = alu_res;
    ex_wb   = 1'b0;
    ex_ctrl = CtrlIdle;
    ex_data = data_q;
    case (opcode)
      OpLui:    begin ex_res = imm_q;         ex_wb = 1'b1; end
      OpAuipc:  begin ex_res = pc_q + imm_q;  ex_wb = 1'b1; end
      OpJal:    begin ex_res = pc_q + 32'd4;  ex_wb = 1'b1; ex_npc = pc_q + imm_q; end
      OpJalr:   begin ex_res = pc_q + 32'd4;  ex_wb = 1'b1; ex_npc = alu_res & ~32'd1; end
      OpBranch: if (br_taken) ex_npc = pc_q + imm_q;
      OpLoad: begin
        // LB/LH/LW/LBU/LHU only; other widths behave as NOPs
        if (funct3[1:0] != 2'b11 && !(funct3[2] && funct3[1])) begin
          ex_wb   = 1'b1;
          ex_ctrl = {funct3[1:0], CtrlRead};
        end
      end
      OpStore: begin
        if (!funct3[2] && funct3[1:0] != 2'b11) begin
          ex_ctrl = {funct3[1:0], CtrlWrite};
          case (funct3[1:0])
            2'b00:   ex_data = {4{rs2_q[7:0]}};
            2'b01:   ex_data = {2{rs2_q[15:0]}};
            default: ex_data = rs2_q;
          endcase
        end
      end
      OpImm, OpReg: ex_wb = 1'b1;
`ifdef CPU_INTERRUPT_EN
      OpSystem: if (ir_q == InstrMret) ex_npc = epc_q;
`endif
      default: ;
    endcase
  end

  always_comb begin
    unique case (addr_q[1:0])
      2'b00: ld_byte = inputdata_from_external_bus[7:0];
      2'b01: ld_byte = inputdata_from_external_bus[15:8];
      2'b10: ld_byte = inputdata_from_external_bus[23:16];
      2'b11: ld_byte = inputdata_from_external_bus[31:24];
    endcase
    ld_half = addr_q[1] ? inputdata_from_external_bus[31:16] : inputdata_from_external_bus[15:0];
    case (funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = inputdata_from_external_bus;
    endcase
  end

  assign wb_data = (opcode == OpLoad) ? ld_val : res_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ctrl_d  = CtrlIdle;
    unique case (state_q)
      StFetch: begin
        // First edge after reset only arms the fetch of PC 0
        if (run_q) state_d = StDecode;
        else       ctrl_d  = CtrlFetch;
      end
      StDecode:  state_d = StExecute;
      StExecute: begin
        state_d = StMemwb;
        if (ex_ctrl != CtrlIdle) begin
          addr_d = alu_res;
          ctrl_d = ex_ctrl;
          data_d = ex_data;
        end
      end
      StMemwb: begin
        state_d = StFetch;
        pc_d    = take_irq ? IrqVector : npc_q;
        addr_d  = pc_d;
        ctrl_d  = CtrlFetch;
      end
    endcase
  end

  always_ff @(posedge clk_from_external or negedge reset_from_external) begin
    if (!reset_from_external) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      npc_q   <= '0;
      wb_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= CtrlIdle;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      if (state_q == StFetch && run_q) ir_q <= inputdata_from_external_bus;
      if (state_q == StDecode) begin
        rs1_q <= rdata_a;
        rs2_q <= rdata_b;
        imm_q <= imm_gen(ir_q);
      end
      if (state_q == StExecute) begin
        res_q <= ex_res;
        npc_q <= ex_npc;
        wb_q  <= ex_wb;
      end
    end
  end

  assign address_to_external_bus_from_cpu = addr_q;
  assign outputdata_to_external_bus       = data_q;
  assign control_output_to_external_bus   = ctrl_q;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed scenarios plus random instructions vs an ISA-level model.
module tb_cpu;

`ifdef CPU_INTERRUPT_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq = 1'b0;
  logic [31:0] bus_in = '0;
  logic [31:0] bus_out, addr;
  logic [3:0]  ctrl;
  logic        grant;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_epc, m_data;
  logic        m_ie, m_grant;

  cpu dut (
    .clk_from_external                (clk),
    .reset_from_external              (rst_n),
    .inputdata_from_external_bus      (bus_in),
    .interrupt_from_external          (irq),
    .outputdata_to_external_bus       (bus_out),
    .address_to_external_bus_from_cpu (addr),
    .control_output_to_external_bus   (ctrl),
    .interrupt_grant_from_pc          (grant)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_init();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0; m_epc = '0; m_data = '0; m_ie = 1'b1; m_grant = 1'b0;
  endtask

  task automatic reset_release();
    rst_n = 1'b1;
    @(negedge clk);
    model_init();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq = 1'b0; bus_in = '0;
    repeat (2) @(negedge clk);
    check("rst_addr", addr, 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_data", bus_out, 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    reset_release();
  endtask

  // Entered just after the negedge inside a FETCH cycle; leaves at the next FETCH.
  task automatic exec_instr(input logic [31:0] ins, input logic [31:0] ld, input logic irq_in);
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] a, b, immi, imms, immb, immu, immj, npc, wv, ea, sdat;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic        wen, take, br;
    logic [3:0]  ectrl;
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
    a = m_regs[ins[19:15]]; b = m_regs[ins[24:20]];
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    immb = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    immu = {ins[31:12], 12'h000};
    immj = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 32'd4; wv = '0; wen = 1'b0; ectrl = 4'd0; ea = '0; sdat = m_data; br = 1'b0;

    check("fetch_addr", addr, m_pc);
    check("fetch_ctrl", 32'(ctrl), 32'h9);
    check("fetch_grant", 32'(grant), 32'(m_grant));
    bus_in = ins; irq = irq_in;
    @(negedge clk);
    check("decode_ctrl", 32'(ctrl), 32'd0);
    check("decode_addr_hold", addr, m_pc);
    check("decode_grant", 32'(grant), 32'd0);
    @(negedge clk);
    check("exec_ctrl", 32'(ctrl), 32'd0);
    check("exec_data_hold", bus_out, m_data);
    bus_in = ld;
    @(negedge clk);

    case (op)
      7'h37: begin wen = 1'b1; wv = immu; end
      7'h17: begin wen = 1'b1; wv = m_pc + immu; end
      7'h6f: begin wen = 1'b1; wv = m_pc + 32'd4; npc = m_pc + immj; end
      7'h67: begin wen = 1'b1; wv = m_pc + 32'd4; npc = (a + immi) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: br = a == b;
          3'd1: br = a != b;
          3'd4: br = $signed(a) < $signed(b);
          3'd5: br = $signed(a) >= $signed(b);
          3'd6: br = a < b;
          3'd7: br = a >= b;
          default: br = 1'b0;
        endcase
        if (br) npc = m_pc + immb;
      end
      7'h03: begin
        if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
          ea = a + immi; ectrl = {f3[1:0], 2'b01}; wen = 1'b1;
          lb = ld[{ea[1:0], 3'b000} +: 8];
          lh = ld[{ea[1], 4'b0000} +: 16];
          case (f3)
            3'd0: wv = {{24{lb[7]}}, lb};
            3'd1: wv = {{16{lh[15]}}, lh};
            3'd4: wv = {24'd0, lb};
            3'd5: wv = {16'd0, lh};
            default: wv = ld;
          endcase
        end
      end
      7'h23: begin
        if (f3 < 3'd3) begin
          ea = a + imms; ectrl = {f3[1:0], 2'b10};
          sdat = (f3 == 3'd0) ? {4{b[7:0]}} : (f3 == 3'd1) ? {2{b[15:0]}} : b;
        end
      end
      7'h13: begin wen = 1'b1; wv = alu_ref(f3, ins[30] && f3 == 3'd5, a, immi); end
      7'h33: begin wen = 1'b1; wv = alu_ref(f3, ins[30], a, b); end
      7'h73: if (IrqEn && ins == 32'h3020_0073) npc = m_epc;
      default: ;
    endcase

    check("mem_ctrl", 32'(ctrl), 32'(ectrl));
    check("mem_addr", addr, (ectrl != 4'd0) ? ea : m_pc);
    check("mem_data", bus_out, sdat);
    m_data = sdat;
    @(negedge clk);

    take = IrqEn && irq_in && m_ie;
    if (IrqEn && ins == 32'h3020_0073) m_ie = 1'b1;
    if (take) begin
      m_epc = npc; npc = 32'h10; m_ie = 1'b0;
    end
    m_grant = take;
    if (wen && rd != 5'd0) m_regs[rd] = wv;
    m_pc = npc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    int          sel;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 11))
      0: begin
        imm = 12'($urandom);
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return {imm, rs1, f3, rd, 7'h13};
      end
      1: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      2: return {20'($urandom), rd, 7'h37};
      3: return {20'($urandom), rd, 7'h17};
      4: return {20'($urandom), rd, 7'h6f};
      5: return {12'($urandom), rs1, 3'b000, rd, 7'h67};
      6: begin
        sel = $urandom_range(0, 5);
        f3 = (sel < 2) ? 3'(sel) : 3'(sel + 2);
        return {7'($urandom), rs2, rs1, f3, 5'($urandom), 7'h63};
      end
      7: begin
        sel = $urandom_range(0, 4);
        f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
        return {12'($urandom), rs1, f3, rd, 7'h03};
      end
      9: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_000F;
          1: return 32'h0000_0073;
          2: return 32'h0010_0073;
          3: return 32'h3020_0073;
          default: return {25'($urandom), 7'h0B};
        endcase
      end
      default: return {7'($urandom), rs2, rs1, 3'($urandom_range(0, 2)), 5'($urandom), 7'h23};
    endcase
  endfunction

  initial begin
    model_init();
    do_reset();

    // SW x2,33(x1) from reset
    exec_instr(32'h0220_A0A3, 32'd0, 1'b0);
    // LUI then SW
    exec_instr(32'h0000_10B7, 32'd0, 1'b0);
    exec_instr(32'h0010_2023, 32'd0, 1'b0);
    // LB / LBU with the instruction word doubling as load data
    exec_instr(32'h0000_0083, 32'h0000_0083, 1'b0);
    exec_instr(32'h0010_2023, 32'd0, 1'b0);
    exec_instr(32'h0000_4083, 32'h0000_4083, 1'b0);
    exec_instr(32'h0010_2023, 32'd0, 1'b0);

    // JAL at PC 8, then a not-taken BNE
    do_reset();
    exec_instr(32'h0000_0013, 32'd0, 1'b0);
    exec_instr(32'h0000_0013, 32'd0, 1'b0);
    exec_instr(32'h0080_00EF, 32'd0, 1'b0);
    exec_instr(32'h0000_8113, 32'd0, 1'b0);
    exec_instr(32'h0020_9463, 32'd0, 1'b0);
    exec_instr(32'h0010_2023, 32'd0, 1'b0);

    // Interrupt held across two instructions, then MRET
    do_reset();
    exec_instr(32'h0000_0013, 32'd0, 1'b0);
    exec_instr(32'h0000_0013, 32'd0, 1'b1);
    exec_instr(32'h0000_0013, 32'd0, 1'b1);
    exec_instr(32'h3020_0073, 32'd0, 1'b0);
    exec_instr(32'h0000_0013, 32'd0, 1'b0);

    // Reset during EXECUTE of ADDI x1,x0,1
    do_reset();
    exec_instr(32'h0000_0013, 32'd0, 1'b0);
    exec_instr(32'h0000_0013, 32'd0, 1'b0);
    check("abort_fetch_addr", addr, m_pc);
    bus_in = 32'h0010_0093;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_addr", addr, 32'd0);
    check("abort_ctrl", 32'(ctrl), 32'd0);
    check("abort_data", bus_out, 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    @(negedge clk);
    reset_release();
    exec_instr(32'h0010_2023, 32'd0, 1'b0);

    // Random instruction stream
    do_reset();
    repeat (300) exec_instr(rand_instr(), $urandom, $urandom_range(0, 7) == 0);
    for (int i = 1; i < 8; i++) begin
      exec_instr({7'd0, 5'(i), 5'd0, 3'b010, 5'd0, 7'h23}, 32'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have port clk_from_external, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_from_external, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port inputdata_from_external_bus, input, 32 bits: instruction or load data from the bus.
REQ-004 SHALL have port interrupt_from_external, input, 1 bit: level-sensitive interrupt request.
REQ-005 SHALL have port outputdata_to_external_bus, output, 32 bits: store data.
REQ-006 SHALL have port address_to_external_bus_from_cpu, output, 32 bits: bus address.
REQ-007 SHALL have port control_output_to_external_bus, output, 4 bits: bus control, encoded as follows.
- [0] read strobe.
- [1] write strobe.
- [3:2] size: 00 byte, 01 half, 10 word.
REQ-008 SHALL have port interrupt_grant_from_pc, output, 1 bit: one-cycle pulse when an interrupt is taken.

Function
REQ-009 SHALL execute RV32I, except FENCE, ECALL and EBREAK, which are NOPs (PC+4).
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM (0010011), OP (0110011), MRET (0x30200073).
REQ-010 SHALL use a 4-state cycle FETCH->DECODE->EXECUTE->MEMWB->FETCH, so each instruction takes exactly 4 clocks.
REQ-011 FETCH SHALL behave as follows.
- Drive address = PC and control = 1001 (word read).
- Latch inputdata into the instruction register on the edge leaving FETCH.
REQ-012 DECODE SHALL read rs1/rs2 from the register file and form the sign-extended I/S/B/U/J immediate.
REQ-013 EXECUTE SHALL compute the ALU result, branch condition and next PC.
- Shifts use operand[4:0].
- SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
REQ-014 MEMWB loads SHALL behave as follows.
- Drive address = rs1+imm and control = read with size.
- Capture inputdata on the edge leaving MEMWB.
- Select the byte/half lane by addr[1:0] (half lane by addr[1]).
- Sign-extend (LB/LH) or zero-extend (LBU/LHU), then write rd.
REQ-015 MEMWB stores SHALL behave as follows.
- Drive address = rs1+imm and control = write with size.
- Drive output data as rs2 with the byte replicated ×4 (SB), half replicated ×2 (SH), or the word (SW).
REQ-016 Outside MEMWB load/store and FETCH, control SHALL be 0000; address and output data SHALL hold their last values.
REQ-017 The register file SHALL hold 32×32 bits, with x0 reading 0 and writes to it ignored; the write happens on the edge leaving MEMWB.
REQ-018 JAL/JALR SHALL write PC+4 to rd; the JALR target SHALL be (rs1+imm) with bit0 cleared.
REQ-019 Branch targets SHALL be PC+imm; misaligned targets SHALL be followed without exception.
REQ-020 Unknown opcodes SHALL be NOPs (PC+4, no register write, no bus write).
REQ-021 Interrupts SHALL be taken as follows.
- Condition: interrupt_from_external=1 sampled in MEMWB while interrupt-enable IE=1.
- EPC <= next PC; PC <= 0x00000010; IE <= 0.
- interrupt_grant_from_pc = 1 for the following FETCH cycle.
REQ-022 MRET SHALL set PC <= EPC and IE <= 1.
REQ-023 An interrupt SHALL NOT be taken while IE=0; the request SHALL remain pending while high.

Reset
REQ-024 While reset_from_external=0, the following SHALL hold.
- PC=0, state=FETCH, IE=1, EPC=0, all registers 0, instruction register 0.
- Address, output data, control and grant all 0.
REQ-025 Reset asserted mid-instruction SHALL abort the instruction immediately with no register write; the first FETCH of address 0 follows the first rising edge after release.

Configuration
REQ-026 With CPU_INTERRUPT_EN defined, REQ-021 to REQ-023 SHALL apply.
REQ-027 Without CPU_INTERRUPT_EN, the interrupt input SHALL be ignored, the grant SHALL be tied 0, MRET SHALL be a NOP, and no EPC/IE logic SHALL exist.

Structure
REQ-028 A shared package cpu_pkg SHALL hold the following.
- State encoding.
- Opcode constants.
- ALU operation enum.
- Bus control constants.
- Interrupt vector 0x10.
REQ-029 The register file SHALL be a sub-module cpu_regfile (2 async read ports, 1 sync write port, async active-low reset).

Verification
REQ-030 Reset released, bus=0x0220A0A3 (SW x2,33(x1)) -> cycle 1 addr 0 control 1001; cycle 4 addr 0x21 control 1010 data 0; next fetch addr 4.
REQ-031 LUI x1,0x1 (0x000010B7), then SW x1,0(x0) (0x00102023) -> x1=0x00001000; store cycle data 0x00001000 addr 0.
REQ-032 Bus=0x00000083 (LB x1,0(x0)) held 4 cycles -> x1=0xFFFFFF83; LBU (0x00004083) -> x1=0x00000083.
REQ-033 JAL x1,+8 (0x008000EF) at PC 8 -> x1=0x0000000C, next fetch 0x10; BNE x1,x2,+8 with x1=x2 -> next fetch PC+4.
REQ-034 Interrupt raised during instruction at PC 4, held 8 cycles -> grant pulses one cycle, next fetch 0x10, EPC=8, no second grant; MRET -> fetch 8.
REQ-035 Reset pulled low during EXECUTE of ADDI x1,x0,1 -> x1 stays 0, all outputs 0, fetch restarts at 0.
